// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite types for the two-master arbiter: transfer/burst encodings,
// arbiter FSM states and the fixed-burst length decode.
package ahb3lite_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } HTRANS_state;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } HBURST_Type;

  typedef enum logic [1:0] {
    ARB_IDLE         = 2'd0,
    ARB_OWN          = 2'd1,
    ARB_LOCKED_BURST = 2'd2
  } arb_state;

  localparam int BEAT_CNT_W = 5;

  // Zero means the burst has no fixed length (SINGLE or INCR).
  function automatic logic [BEAT_CNT_W-1:0] burst_beats(input HBURST_Type burst);
    logic [BEAT_CNT_W-1:0] beats;
    case (burst)
      WRAP4, INCR4:   beats = BEAT_CNT_W'(4);
      WRAP8, INCR8:   beats = BEAT_CNT_W'(8);
      WRAP16, INCR16: beats = BEAT_CNT_W'(16);
      default:        beats = '0;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ahb3lite_arb_rr2.sv
// Two-way round-robin decision: picks the next owner from the current requests
// and remembers who was granted last so ties alternate.
module ahb3lite_arb_rr2
  import ahb3lite_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       arb_en,
  output logic [1:0] grant
);

  logic last_q, last_d;

  always_comb begin
    grant  = 2'b00;
    last_d = last_q;
    case (req)
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      default: grant = 2'b00;
    endcase
    if (arb_en && (grant != 2'b00)) begin
      last_d = grant[1];
    end
  end

  // last starts at 1 so master 0 wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ahb3lite_arbiter_2m.sv
// Two-master AHB3-Lite arbiter: grant FSM with fixed-burst locking and an INCR
// hold limit, plus the address-phase and data-phase multiplexers to the slave.
module ahb3lite_arbiter_2m
  import ahb3lite_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int NUM_M    = 2
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_M-1:0]       M_HBUSREQ,
  input  logic [NUM_M-1:0][31:0] M_HADDR,
  input  logic [NUM_M-1:0][1:0]  M_HTRANS,
  input  logic [NUM_M-1:0][2:0]  M_HBURST,
  input  logic [NUM_M-1:0][2:0]  M_HSIZE,
  input  logic [NUM_M-1:0]       M_HWRITE,
  input  logic [NUM_M-1:0][31:0] M_HWDATA,
  output logic [NUM_M-1:0]       HGRANT,
  output logic                   HMASTER,
  output logic [31:0]            HADDR,
  output logic [1:0]             HTRANS,
  output logic [2:0]             HBURST,
  output logic [2:0]             HSIZE,
  output logic                   HWRITE,
  output logic [31:0]            HWDATA,
  input  logic                   HREADYOUT,
  output logic                   HREADY,
  output logic [1:0]             dbg_state
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state                state_q, state_d;
  logic [NUM_M-1:0]        hgrant_q, hgrant_d;
  logic                    hmaster_q, hmaster_d;
  logic                    downer_q, downer_d;
  logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [HOLD_W-1:0]       incr_cnt_q, incr_cnt_d;

  HTRANS_state own_trans;
  HBURST_Type  own_burst;
  logic        own_req, other_req;
  logic        accepted, lock_start, final_beat, hold_hit, release_own, arb_pt;
  logic [1:0]  rr_grant;

  ahb3lite_arb_rr2 u_rr (
    .clk    (HCLK),
    .rst    (HRESET),
    .req    (M_HBUSREQ),
    .arb_en (arb_pt),
    .grant  (rr_grant)
  );

  always_comb begin
    own_trans = HTRANS_state'(M_HTRANS[hmaster_q]);
    own_burst = HBURST_Type'(M_HBURST[hmaster_q]);
    own_req   = M_HBUSREQ[hmaster_q];
    other_req = M_HBUSREQ[~hmaster_q];

    // BUSY is deliberately excluded: it neither counts as a beat nor releases the bus.
    accepted    = HREADYOUT && (state_q != ARB_IDLE) &&
                  ((own_trans == NONSEQ) || (own_trans == SEQ));
    lock_start  = (state_q == ARB_OWN) && accepted && (own_trans == NONSEQ) &&
                  (burst_beats(own_burst) != '0);
    final_beat  = (state_q == ARB_LOCKED_BURST) && accepted &&
                  (beat_cnt_q == BEAT_CNT_W'(1));
    hold_hit    = accepted && (own_burst == INCR) && (incr_cnt_q >= HOLD_LAST) && other_req;
    release_own = (own_trans == IDLE) || !own_req || hold_hit ||
                  (accepted && (own_trans == NONSEQ) && (own_burst == SINGLE));

    arb_pt = 1'b0;
    case (state_q)
      ARB_IDLE:         arb_pt = HREADYOUT;
      ARB_OWN:          arb_pt = HREADYOUT && !lock_start && release_own;
      ARB_LOCKED_BURST: arb_pt = final_beat;
      default:          arb_pt = HREADYOUT;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    hgrant_d   = hgrant_q;
    hmaster_d  = hmaster_q;
    downer_d   = downer_q;
    beat_cnt_d = beat_cnt_q;
    incr_cnt_d = incr_cnt_q;

    if (HREADYOUT) begin
      downer_d = hmaster_q;
    end

    // The NONSEQ that opens a fixed burst is itself the first beat.
    if (lock_start) begin
      state_d    = ARB_LOCKED_BURST;
      beat_cnt_d = burst_beats(own_burst) - BEAT_CNT_W'(1);
    end else if ((state_q == ARB_LOCKED_BURST) && accepted) begin
      beat_cnt_d = beat_cnt_q - BEAT_CNT_W'(1);
    end

    if ((state_q == ARB_OWN) && accepted && (own_burst == INCR) && (incr_cnt_q != HOLD_MAX)) begin
      incr_cnt_d = incr_cnt_q + HOLD_W'(1);
    end

    if (arb_pt) begin
      hgrant_d = rr_grant;
      if (rr_grant != hgrant_q) begin
        incr_cnt_d = '0;
      end
      if (rr_grant == 2'b00) begin
        state_d = ARB_IDLE;
      end else begin
        state_d   = ARB_OWN;
        hmaster_d = rr_grant[1];
      end
    end
  end

  // Reset wins over everything, including a burst in flight.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= ARB_IDLE;
      hgrant_q   <= '0;
      hmaster_q  <= 1'b0;
      downer_q   <= 1'b0;
      beat_cnt_q <= '0;
      incr_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hgrant_q   <= hgrant_d;
      hmaster_q  <= hmaster_d;
      downer_q   <= downer_d;
      beat_cnt_q <= beat_cnt_d;
      incr_cnt_q <= incr_cnt_d;
    end
  end

  always_comb begin
    HGRANT    = hgrant_q;
    HMASTER   = hmaster_q;
    HADDR     = (hgrant_q != '0) ? M_HADDR[hmaster_q] : 32'h0;
    HTRANS    = (hgrant_q != '0) ? M_HTRANS[hmaster_q] : IDLE;
    HBURST    = M_HBURST[hmaster_q];
    HSIZE     = M_HSIZE[hmaster_q];
    HWRITE    = M_HWRITE[hmaster_q];
    HWDATA    = M_HWDATA[downer_q];
    HREADY    = HREADYOUT;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_ahb3lite_arbiter_2m.sv
// Bench for the two-master AHB3-Lite arbiter: directed scenarios plus a
// randomized run checked against a rule-level reference model.
module tb_ahb3lite_arbiter_2m;
  import ahb3lite_pkg::*;

  localparam int MAX_HOLD = 16;

  logic            HCLK;
  logic            HRESET;
  logic [1:0]      M_HBUSREQ;
  logic [1:0][31:0] M_HADDR;
  logic [1:0][1:0] M_HTRANS;
  logic [1:0][2:0] M_HBURST;
  logic [1:0][2:0] M_HSIZE;
  logic [1:0]      M_HWRITE;
  logic [1:0][31:0] M_HWDATA;
  logic [1:0]      HGRANT;
  logic            HMASTER;
  logic [31:0]     HADDR;
  logic [1:0]      HTRANS;
  logic [2:0]      HBURST;
  logic [2:0]      HSIZE;
  logic            HWRITE;
  logic [31:0]     HWDATA;
  logic            HREADYOUT;
  logic            HREADY;
  logic [1:0]      dbg_state;

  int checks = 0;
  int errors = 0;

  ahb3lite_arbiter_2m #(.MAX_HOLD(MAX_HOLD), .NUM_M(2)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .M_HBUSREQ(M_HBUSREQ), .M_HADDR(M_HADDR),
    .M_HTRANS(M_HTRANS), .M_HBURST(M_HBURST), .M_HSIZE(M_HSIZE), .M_HWRITE(M_HWRITE),
    .M_HWDATA(M_HWDATA), .HGRANT(HGRANT), .HMASTER(HMASTER), .HADDR(HADDR),
    .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HREADY(HREADY), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Reference model: owner is -1 when nobody holds the bus; left counts
  // remaining beats of a fixed burst; hold counts accepted INCR beats.
  int m_owner = -1, m_hmaster = 0, m_last = 1, m_left = 0, m_hold = 0, m_downer = 0;

  always @(posedge HCLK) begin : model
    int o, t, b, pick;
    bit acc, rel;
    if (HRESET) begin
      m_owner = -1; m_hmaster = 0; m_last = 1; m_left = 0; m_hold = 0; m_downer = 0;
    end else if (HREADYOUT) begin
      o = m_hmaster;
      t = int'(M_HTRANS[o]);
      b = int'(M_HBURST[o]);
      acc = (m_owner >= 0) && (t >= 2);
      rel = 1'b0;
      m_downer = m_hmaster;
      if (m_owner < 0) rel = 1'b1;
      else if (m_left > 0) begin
        if (acc) begin
          m_left = m_left - 1;
          rel = (m_left == 0);
        end
      end else if (acc && t == 2 && b >= 2) m_left = (4 << ((b - 2) / 2)) - 1;
      else begin
        if (acc && b == 1 && m_hold < MAX_HOLD) m_hold = m_hold + 1;
        rel = (t == 0) || !M_HBUSREQ[o] || (acc && t == 2 && b == 0) ||
              (acc && b == 1 && m_hold >= MAX_HOLD && M_HBUSREQ[1-o]);
      end
      if (rel) begin
        if (M_HBUSREQ == 2'b11) pick = 1 - m_last;
        else if (M_HBUSREQ[0]) pick = 0;
        else if (M_HBUSREQ[1]) pick = 1;
        else pick = -1;
        if (pick != m_owner) m_hold = 0;
        if (pick >= 0) begin
          m_last = pick;
          m_hmaster = pick;
        end
        m_owner = pick;
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(negedge HCLK);
  endtask

  task automatic idle_inputs();
    M_HBUSREQ = 2'b00;
    M_HTRANS  = '0;
    M_HBURST  = '0;
    M_HSIZE   = '0;
    M_HWRITE  = 2'b00;
    M_HADDR[0] = 32'h0000_1234;
    M_HADDR[1] = 32'h0000_5678;
    M_HWDATA[0] = 32'hD0D0_0000;
    M_HWDATA[1] = 32'hD1D1_1111;
    HREADYOUT = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    HRESET = 1'b1;
    step();
    step();
    HRESET = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    HRESET = 1'b1;
    step();
    checks++; if (HGRANT !== 2'b00) begin errors++; $display("FAIL reset_hgrant: got %b want 00", HGRANT); end
    checks++; if (HMASTER !== 1'b0) begin errors++; $display("FAIL reset_hmaster: got %b want 0", HMASTER); end
    checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL reset_htrans: got %b want 00", HTRANS); end
    checks++; if (HADDR !== 32'h0) begin errors++; $display("FAIL reset_haddr: got %h want 0", HADDR); end
    checks++; if (dbg_state !== ARB_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ARB_IDLE); end
    checks++; if (HWDATA !== 32'hD0D0_0000) begin errors++; $display("FAIL reset_hwdata: got %h want d0d00000", HWDATA); end
    HRESET = 1'b0;
  endtask

  task automatic test_round_robin();
    do_reset();
    M_HBUSREQ = 2'b11;
    step();
    checks++; if (HGRANT !== 2'b01) begin errors++; $display("FAIL rr_first_tie: got %b want 01", HGRANT); end
    M_HTRANS[0] = NONSEQ; M_HBURST[0] = INCR; M_HADDR[0] = 32'h10;
    step();
    checks++; if (HGRANT !== 2'b01) begin errors++; $display("FAIL rr_hold_nonseq: got %b want 01", HGRANT); end
    checks++; if (HADDR !== 32'h10) begin errors++; $display("FAIL rr_haddr_mux: got %h want 10", HADDR); end
    checks++; if (HTRANS !== 2'b10) begin errors++; $display("FAIL rr_htrans_mux: got %b want 10", HTRANS); end
    M_HTRANS[0] = SEQ; M_HADDR[0] = 32'h14;
    step();
    checks++; if (HGRANT !== 2'b01) begin errors++; $display("FAIL rr_hold_seq: got %b want 01", HGRANT); end
    M_HBUSREQ[0] = 1'b0; M_HTRANS[0] = IDLE;
    step();
    checks++; if (HGRANT !== 2'b10) begin errors++; $display("FAIL rr_handover: got %b want 10", HGRANT); end
    checks++; if (HMASTER !== 1'b1) begin errors++; $display("FAIL rr_hmaster: got %b want 1", HMASTER); end
    checks++; if (HADDR !== 32'h0000_5678) begin errors++; $display("FAIL rr_haddr_m1: got %h want 00005678", HADDR); end
  endtask

  task automatic test_incr4_lock();
    do_reset();
    M_HBUSREQ = 2'b10;
    step();
    M_HBUSREQ = 2'b11;
    M_HTRANS[1] = NONSEQ; M_HBURST[1] = INCR4; M_HADDR[1] = 32'h100;
    step();
    checks++; if (HGRANT !== 2'b10) begin errors++; $display("FAIL incr4_beat1: got %b want 10", HGRANT); end
    checks++; if (dbg_state !== ARB_LOCKED_BURST) begin errors++; $display("FAIL incr4_state: got %0d want %0d", dbg_state, ARB_LOCKED_BURST); end
    checks++; if (HADDR !== 32'h100) begin errors++; $display("FAIL incr4_haddr: got %h want 100", HADDR); end
    for (int k = 2; k <= 4; k++) begin
      M_HTRANS[1] = SEQ; M_HADDR[1] = 32'h100 + 32'(4 * (k - 1));
      step();
      checks++;
      if (HGRANT !== ((k < 4) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL incr4_beat%0d: got %b want %b", k, HGRANT, (k < 4) ? 2'b10 : 2'b01);
      end
    end
    checks++; if (HMASTER !== 1'b0) begin errors++; $display("FAIL incr4_after_hmaster: got %b want 0", HMASTER); end
  endtask

  task automatic test_wait_states();
    do_reset();
    M_HBUSREQ = 2'b10;
    step();
    M_HBUSREQ = 2'b11;
    M_HTRANS[1] = NONSEQ; M_HBURST[1] = INCR4; M_HADDR[1] = 32'h100;
    step();
    M_HTRANS[1] = SEQ; M_HADDR[1] = 32'h104;
    HREADYOUT = 1'b0;
    for (int w = 0; w < 3; w++) begin
      M_HBUSREQ = 2'($urandom_range(0, 3));
      step();
      checks++; if (HGRANT !== 2'b10) begin errors++; $display("FAIL wait_grant%0d: got %b want 10", w, HGRANT); end
      checks++; if (HWDATA !== 32'hD1D1_1111) begin errors++; $display("FAIL wait_hwdata%0d: got %h want d1d11111", w, HWDATA); end
      checks++; if (HREADY !== 1'b0) begin errors++; $display("FAIL wait_hready%0d: got %b want 0", w, HREADY); end
    end
    M_HBUSREQ = 2'b11;
    HREADYOUT = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      M_HADDR[1] = 32'h100 + 32'(4 * (k - 1));
      step();
      checks++;
      if (HGRANT !== ((k < 4) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL wait_resume_beat%0d: got %b want %b", k, HGRANT, (k < 4) ? 2'b10 : 2'b01);
      end
    end
  endtask

  task automatic test_max_hold();
    do_reset();
    M_HBUSREQ = 2'b01;
    step();
    M_HBUSREQ = 2'b11;
    M_HTRANS[0] = NONSEQ; M_HBURST[0] = INCR;
    for (int k = 1; k <= MAX_HOLD; k++) begin
      step();
      checks++;
      if (HGRANT !== ((k < MAX_HOLD) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL max_hold_beat%0d: got %b want %b", k, HGRANT, (k < MAX_HOLD) ? 2'b01 : 2'b10);
      end
      M_HTRANS[0] = SEQ;
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    M_HBUSREQ = 2'b10;
    step();
    M_HTRANS[1] = NONSEQ; M_HBURST[1] = INCR8;
    step();
    M_HTRANS[1] = SEQ;
    HRESET = 1'b1;
    step();
    checks++; if (HGRANT !== 2'b00) begin errors++; $display("FAIL midrst_hgrant: got %b want 00", HGRANT); end
    checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL midrst_htrans: got %b want 00", HTRANS); end
    checks++; if (dbg_state !== ARB_IDLE) begin errors++; $display("FAIL midrst_state: got %0d want %0d", dbg_state, ARB_IDLE); end
    checks++; if (HMASTER !== 1'b0) begin errors++; $display("FAIL midrst_hmaster: got %b want 0", HMASTER); end
    HRESET = 1'b0;
  endtask

  task automatic test_no_requests();
    do_reset();
    M_HBUSREQ = 2'b01;
    step();
    M_HBUSREQ = 2'b00;
    M_HTRANS[0] = NONSEQ; M_HBURST[0] = SINGLE; M_HADDR[0] = 32'h40;
    step();
    checks++; if (HGRANT !== 2'b00) begin errors++; $display("FAIL noreq_hgrant: got %b want 00", HGRANT); end
    checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL noreq_htrans: got %b want 00", HTRANS); end
    checks++; if (HADDR !== 32'h0) begin errors++; $display("FAIL noreq_haddr: got %h want 0", HADDR); end
    checks++; if (dbg_state !== ARB_IDLE) begin errors++; $display("FAIL noreq_state: got %0d want %0d", dbg_state, ARB_IDLE); end
  endtask

  task automatic test_random();
    logic [1:0]  e_grant, e_trans, e_state;
    logic [31:0] e_addr, e_wdata;
    logic [2:0]  e_burst;
    int bad;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      HRESET = ($urandom_range(0, 299) == 0);
      HREADYOUT = ($urandom_range(0, 4) != 0);
      for (int m = 0; m < 2; m++) begin
        int r;
        M_HBUSREQ[m] = ($urandom_range(0, 4) != 0);
        r = $urandom_range(0, 19);
        M_HTRANS[m] = (r < 8) ? 2'b11 : (r < 14) ? 2'b10 : (r < 17) ? 2'b00 : 2'b01;
        M_HBURST[m] = 3'($urandom_range(0, 7));
        M_HSIZE[m]  = 3'($urandom_range(0, 2));
        M_HWRITE[m] = 1'($urandom_range(0, 1));
        M_HADDR[m]  = $urandom;
        M_HWDATA[m] = $urandom;
      end
      step();
      e_grant = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
      e_trans = (m_owner < 0) ? 2'b00 : M_HTRANS[m_hmaster];
      e_addr  = (m_owner < 0) ? 32'h0 : M_HADDR[m_hmaster];
      e_burst = M_HBURST[m_hmaster];
      e_wdata = M_HWDATA[m_downer];
      e_state = (m_owner < 0) ? ARB_IDLE : ((m_left > 0) ? ARB_LOCKED_BURST : ARB_OWN);
      bad = 0;
      checks++; if (HGRANT !== e_grant) begin bad++; $display("FAIL rand_hgrant c%0d: got %b want %b", c, HGRANT, e_grant); end
      checks++; if (HMASTER !== 1'(m_hmaster)) begin bad++; $display("FAIL rand_hmaster c%0d: got %b want %0d", c, HMASTER, m_hmaster); end
      checks++; if (HTRANS !== e_trans) begin bad++; $display("FAIL rand_htrans c%0d: got %b want %b", c, HTRANS, e_trans); end
      checks++; if (HADDR !== e_addr) begin bad++; $display("FAIL rand_haddr c%0d: got %h want %h", c, HADDR, e_addr); end
      checks++; if (HBURST !== e_burst) begin bad++; $display("FAIL rand_hburst c%0d: got %0d want %0d", c, HBURST, e_burst); end
      checks++; if (HWDATA !== e_wdata) begin bad++; $display("FAIL rand_hwdata c%0d: got %h want %h", c, HWDATA, e_wdata); end
      checks++; if (dbg_state !== e_state) begin bad++; $display("FAIL rand_state c%0d: got %0d want %0d", c, dbg_state, e_state); end
      checks++; if (HREADY !== HREADYOUT) begin bad++; $display("FAIL rand_hready c%0d: got %b want %b", c, HREADY, HREADYOUT); end
      errors += bad;
      if (errors > 40) begin
        $display("FAIL rand_abort: too many errors (%0d), stopping random phase", errors);
        break;
      end
    end
    HRESET = 1'b0;
  endtask

  initial begin
    HRESET = 1'b1;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_incr4_lock();
    test_wait_states();
    test_max_hold();
    test_reset_mid_burst();
    test_no_requests();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb3lite_arbiter_2m.md
AHB3LITE_ARBITER_2M -- requirements
Module: ahb3lite_arbiter_2m

Interface
Parameters:
REQ-001 MAX_HOLD, 16, maximum beats an INCR (undefined-length) owner keeps the bus while the other master is requesting.
REQ-002 NUM_M, 2, number of masters; fixed at 2 in this revision.

Ports (M_* buses are packed [1:0] arrays indexed by master):
REQ-003 HCLK  in  1  bus clock; all logic on the rising edge.
REQ-004 HRESET  in  1  synchronous, active-high reset.
REQ-005 M_HBUSREQ  in  2  per-master bus request.
REQ-006 M_HADDR  in  2x32  per-master address.
REQ-007 M_HTRANS  in  2xHTRANS_state  per-master transfer type.
REQ-008 M_HBURST  in  2xHBURST_Type  per-master burst type.
REQ-009 M_HSIZE  in  2x3  per-master size.
REQ-010 M_HWRITE  in  2x1  per-master direction.
REQ-011 M_HWDATA  in  2x32  per-master write data.
REQ-012 HGRANT  out  2  one-hot grant, or 0 when no master is granted.
REQ-013 HMASTER  out  1  address-phase owner index.
REQ-014 HADDR, HTRANS, HBURST, HSIZE, HWRITE  out  (slave widths)  muxed address-phase controls to the slave.
REQ-015 HWDATA  out  32  write data muxed by the data-phase owner.
REQ-016 HREADYOUT  in  1  slave ready; HREADY  out  1  copy of it broadcast to the masters.

Function
REQ-017 FSM states: ARB_IDLE (no grant), ARB_OWN (granted master drives the bus), ARB_LOCKED_BURST (fixed-length burst in progress).
REQ-018 Arbitration point: HREADYOUT=1 and one of the following:
- state is ARB_IDLE;
- owner's HTRANS=IDLE;
- owner's HBUSREQ=0;
- a SINGLE NONSEQ is accepted;
- a fixed burst's final beat is accepted;
- the INCR beat count reaches MAX_HOLD while the other master requests.
REQ-019 Round-robin: with both masters requesting, grant the master not granted last; with one requesting, grant that master; with none, enter ARB_IDLE with HGRANT=0.
REQ-020 HGRANT and HMASTER are registered and change only at an arbitration point, one cycle after the deciding edge.
REQ-021 A NONSEQ with HBURST in {INCR4, INCR8, INCR16, WRAP4, WRAP8, WRAP16} enters ARB_LOCKED_BURST and loads a beat counter with 4/8/16.
- The counter decrements on each accepted beat (HREADYOUT=1, HTRANS in {NONSEQ, SEQ}).
- The grant cannot change until the counter reaches 0.
REQ-022 BUSY beats do not decrement any counter and do not create an arbitration point.
REQ-023 In INCR, a counter counts accepted beats and clears on grant change. If it equals MAX_HOLD while the other master requests, the arbiter rearbitrates even though HBUSREQ is still high.
REQ-024 Slave-side controls are combinational muxes of M_* selected by HMASTER. When HGRANT=0, HTRANS is forced to IDLE and HADDR to 0.
REQ-025 A data-phase owner register loads HMASTER when HREADYOUT=1 and selects HWDATA. It holds during wait states (HREADYOUT=0).
REQ-026 HREADY = HREADYOUT, combinational, zero latency.
REQ-027 If HREADYOUT=0, no state, grant, counter or owner register changes, whatever the request inputs do.
REQ-028 When a request and a release occur in the same cycle, the release is evaluated first, then round-robin selection applies to the current requests.

Reset
REQ-029 On HRESET=1 at a clock edge, the block takes these values:
- state ARB_IDLE, HGRANT=0, HMASTER=0;
- data-phase owner 0, counters 0;
- last-granted=1, so master 0 wins the first tie.
REQ-030 While no master is granted, slave-side HTRANS is IDLE.
REQ-031 Reset asserted mid-burst aborts immediately. No completion of the burst is attempted.

Structure
REQ-032 HTRANS_state, HBURST_Type and the new arb_state enum belong in ahb3lite_pkg.
REQ-033 The burst-length decode (HBURST to beat count) belongs in ahb3lite_pkg as a function.
REQ-034 One sub-module, ahb3lite_arb_rr2, holds the round-robin pointer and grant decision. The top level holds the FSM, counters and muxes.

Verification
REQ-035 Reset, then M_HBUSREQ=2'b11 -> HGRANT=2'b01 one cycle later; after master 0 releases, HGRANT=2'b10 on the next arbitration point.
REQ-036 Master 1 issues INCR4 at 0x100 while master 0 requests -> HGRANT stays 2'b10 for 4 accepted beats, then switches to 2'b01.
REQ-037 INCR4 with HREADYOUT held low 3 cycles on beat 2 -> no grant change and no counter decrement; HWDATA stays master 1's data.
REQ-038 MAX_HOLD=16, master 0 INCR with master 1 requesting -> grant moves to master 1 after beat 16 is accepted.
REQ-039 HRESET pulsed during beat 2 of INCR8 -> next cycle HGRANT=0, HTRANS=IDLE, state ARB_IDLE.
REQ-040 No requests after a transfer -> HGRANT=0, HTRANS=IDLE, HADDR=0.
